// File: rtl/b_feeder_pkg.sv
// Shared systolic-array definitions.
//   DEFAULT_BITS_AB : default signed element width of the A/B operands
//   DEFAULT_DIM     : default systolic array dimension
//   feeder_state_t  : state encoding of the B-tile feeder
package b_feeder_pkg;

  localparam int DEFAULT_BITS_AB = 8;
  localparam int DEFAULT_DIM     = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/b_feeder.sv
// B-tile feeder: loads one DIM x DIM tile of B row by row and presents each
// row, unpacked into signed elements, to the B column skew FIFOs. After the
// last row it pushes 2*DIM-1 zero rows so that the deepest column FIFO is
// flushed, and then pulses done for one cycle.
//
// Ports
//   clk      : clock, all state changes on its rising edge
//   rst      : asynchronous active-high reset
//   start    : one-cycle request to load a tile (honoured only while idle)
//   in_valid : in_data holds a valid row
//   in_data  : packed row; element c at [c*BITS_AB +: BITS_AB]
//   in_ready : row is accepted on a cycle with in_valid && in_ready
//   en       : shift enable for the downstream skew FIFOs (registered)
//   Bout     : unpacked row for the skew FIFO column inputs (registered)
//   busy     : feeder is not idle
//   done     : one-cycle pulse when the tile has been fully flushed
import b_feeder_pkg::*;

module b_feeder #(
  parameter int BITS_AB = DEFAULT_BITS_AB,
  parameter int DIM     = DEFAULT_DIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [BITS_AB*DIM-1:0]    in_data,
  output logic                      in_ready,
  output logic                      en,
  output logic signed [BITS_AB-1:0] Bout [DIM-1:0],
  output logic                      busy,
  output logic                      done
);

  localparam int ROW_W   = $clog2(DIM + 1);
  localparam int DRAIN_W = $clog2(2 * DIM);

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(DIM - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(2 * DIM - 1);

  feeder_state_t      state;
  feeder_state_t      next_state;
  logic [ROW_W-1:0]   row_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  // NOTE: next_state gets its default before the case so that no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (accept && row_cnt == LAST_ROW) next_state = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // DRAIN spans 2*DIM cycles: its first cycle still shows the last loaded
  // row (one-cycle output latency), the remaining 2*DIM-1 show zeros, and
  // the DONE cycle that follows sees en low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt   <= '0;
      drain_cnt <= '0;
      en        <= 1'b0;
      // NOTE: Bout is a handful of output flops, not a RAM, so resetting it
      // is cheap and guarantees the FIFOs see zeros after reset.
      for (int c = 0; c < DIM; c++) Bout[c] <= '0;
    end else begin
      en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) row_cnt <= '0;
        end
        LOAD: begin
          if (accept) begin
            en <= 1'b1;
            for (int c = 0; c < DIM; c++)
              Bout[c] <= signed'(in_data[c*BITS_AB +: BITS_AB]);
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LAST_ROW) drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt != LAST_DRAIN) begin
            en        <= 1'b1;
            drain_cnt <= drain_cnt + 1'b1;
            for (int c = 0; c < DIM; c++) Bout[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_b_feeder.sv
// Directed self-checking bench for b_feeder (DIM=8, BITS_AB=8).
module tb_b_feeder;

  localparam int DIM     = 8;
  localparam int BITS_AB = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic                      in_valid;
  logic [BITS_AB*DIM-1:0]    in_data;
  logic                      in_ready;
  logic                      en;
  logic signed [BITS_AB-1:0] bout [DIM-1:0];
  logic                      busy;
  logic                      done;

  int n_checks = 0;
  int n_fail   = 0;

  b_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .en       (en),
    .Bout     (bout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row r, element c = r*8 + c.
  function automatic logic [BITS_AB*DIM-1:0] make_row(input int r);
    logic [BITS_AB*DIM-1:0] row;
    for (int c = 0; c < DIM; c++) row[c*BITS_AB +: BITS_AB] = BITS_AB'(r * DIM + c);
    return row;
  endfunction

  function automatic bit bout_is_row(input int r);
    logic [BITS_AB*DIM-1:0] row;
    row = make_row(r);
    for (int c = 0; c < DIM; c++)
      if (bout[c] !== row[c*BITS_AB +: BITS_AB]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit bout_is_zero();
    for (int c = 0; c < DIM; c++)
      if (bout[c] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one tile, sampling every falling edge; k=1 is the first cycle after
  // the start edge. Rows are fed as fast as allowed unless stalled.
  task automatic run_tile(input bit stalls, input bit inject,
                          output int done_k, output int busy_n, output int rows_seen,
                          output int zeros_n, output int gaps_n, output int bad_n,
                          output int done_n, output int post_busy);
    int rows_sent  = 0;
    int stall_left = 0;
    done_k = -1; busy_n = 0; rows_seen = 0; zeros_n = 0;
    gaps_n = 0;  bad_n = 0;  done_n = 0;    post_busy = -1;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (en && rows_seen < DIM) begin
        if (!bout_is_row(rows_seen)) bad_n++;
        rows_seen++;
      end else if (en) begin
        if (bout_is_zero()) zeros_n++;
        else bad_n++;
      end else if (rows_seen > 0 && rows_seen < DIM) begin
        gaps_n++;
        if (!bout_is_row(rows_seen - 1)) bad_n++;
      end
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (done_k > 0 && k == done_k + 1) begin
        post_busy = int'(busy);
        break;
      end
      start = inject && (k == 4 || k == 15 || done);
      if (stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = (rows_sent < DIM) || inject;
      end
      in_data = make_row(rows_sent);
      if (in_valid && in_ready) begin
        rows_sent++;
        if (stalls && (rows_sent == 3 || rows_sent == 6)) stall_left = 3;
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  int done_k, busy_n, rows_seen, zeros_n, gaps_n, bad_n, done_n, post_busy;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state, before and after clock edges.
    #1;
    check("rst_en_async", en, 0);
    check("rst_busy_async", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    for (int c = 0; c < DIM; c++) check("rst_bout", bout[c], 0);
    rst = 1'b0;

    // in_valid while idle is ignored.
    in_valid = 1'b1; in_data = make_row(9);
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_en", en, 0);
    end
    in_valid = 1'b0;

    // Back-to-back tile with start pulses in LOAD/DRAIN/DONE and in_valid
    // held high through DRAIN.
    run_tile(1'b0, 1'b1, done_k, busy_n, rows_seen, zeros_n, gaps_n, bad_n, done_n, post_busy);
    check("b2b_done_cycle", done_k, 25);
    check("b2b_busy_cycles", busy_n, 25);
    check("b2b_rows", rows_seen, 8);
    check("b2b_zero_rows", zeros_n, 15);
    check("b2b_gaps", gaps_n, 0);
    check("b2b_bad_data", bad_n, 0);
    check("b2b_done_pulses", done_n, 1);
    check("b2b_idle_after_done", post_busy, 0);

    // Stalls of 3 cycles after rows 2 and 5.
    run_tile(1'b1, 1'b0, done_k, busy_n, rows_seen, zeros_n, gaps_n, bad_n, done_n, post_busy);
    check("stall_done_cycle", done_k, 31);
    check("stall_busy_cycles", busy_n, 31);
    check("stall_rows", rows_seen, 8);
    check("stall_zero_rows", zeros_n, 15);
    check("stall_gaps", gaps_n, 6);
    check("stall_bad_data", bad_n, 0);
    check("stall_done_pulses", done_n, 1);

    // Signed extremes, then reset in the middle of DRAIN.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("sgn_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = {DIM{8'h80}};
    @(negedge clk);
    check("sgn_en", en, 1);
    for (int c = 0; c < DIM; c++) check("sgn_min", bout[c], -128);
    in_data = {DIM{8'h7F}};
    @(negedge clk);
    for (int c = 0; c < DIM; c++) check("sgn_max", bout[c], 127);
    in_data = '0;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_en_before_rst", en, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bout_zero", int'(bout_is_zero()), 1);
    @(negedge clk); rst = 1'b0;
    done_n = 0; busy_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("abandon_no_done", done_n, 0);
    check("abandon_stays_idle", busy_n, 0);

    // Start is honoured right after reset.
    run_tile(1'b0, 1'b0, done_k, busy_n, rows_seen, zeros_n, gaps_n, bad_n, done_n, post_busy);
    check("post_rst_done_cycle", done_k, 25);
    check("post_rst_bad_data", bad_n, 0);
    check("post_rst_zero_rows", zeros_n, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
